// File: rtl/grf_scoreboard_pkg.sv
// Shared definitions for the general register file with pending-write scoreboard.
package grf_scoreboard_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_ZERO   = 0;

   // LSB position of port k inside a packed vector of w-bit fields.
   function automatic int port_lsb(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/grf_scoreboard_if.sv
// Read, write, issue and status signals of the register file scoreboard.
interface grf_scoreboard_if
   import grf_scoreboard_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2
) ();
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr0_en;
   logic [ADDR_W-1:0]        wr0_addr;
   logic [DATA_W-1:0]        wr0_data;
   logic                     wr0_clr;
   logic                     wr1_en;
   logic [ADDR_W-1:0]        wr1_addr;
   logic [DATA_W-1:0]        wr1_data;
   logic                     wr1_clr;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     sb_err;

   modport master (
      output rd_addr, wr0_en, wr0_addr, wr0_data, wr0_clr,
             wr1_en, wr1_addr, wr1_data, wr1_clr, iss_en, iss_addr,
      input  rd_data, rd_busy, sb_err
   );

   modport slave (
      input  rd_addr, wr0_en, wr0_addr, wr0_data, wr0_clr,
             wr1_en, wr1_addr, wr1_data, wr1_clr, iss_en, iss_addr,
      output rd_data, rd_busy, sb_err
   );
endinterface

// File: rtl/grf_sb_counter.sv
// Saturating pending-write counter: +inc, -dec per cycle, flags over/underflow.
module grf_sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             inc,
   input  logic [1:0]       dec,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf,
   output logic             unf
);
   localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W:0]   sum;
   logic [CNT_W:0]   dec_w;
   logic [CNT_W:0]   diff;

   // Clamp to [0, CNT_MAX]; the extra bit keeps overflow distinguishable.
   function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W:0] s,
                                                 input logic [CNT_W:0] d);
      logic [CNT_W:0] r;
      r = s - d;
      if (s < d)
         return '0;
      else if (r > CNT_MAX)
         return CNT_MAX[CNT_W-1:0];
      else
         return r[CNT_W-1:0];
   endfunction

   assign sum   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
   assign dec_w = (CNT_W+1)'(dec);
   assign diff  = sum - dec_w;
   assign unf   = (sum < dec_w);
   assign ovf   = !unf && (diff > CNT_MAX);
   assign cnt   = cnt_q;

   always_ff @(posedge Clk) begin
      if (Reset)
         cnt_q <= '0;
      else
         cnt_q <= sat_next(sum, dec_w);
   end
endmodule

// File: rtl/grf_scoreboard.sv
// General register file: NUM_RD async reads, two prioritised writes, optional
// same-cycle bypass and a per-register pending-write scoreboard.
module grf_scoreboard
   import grf_scoreboard_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1,
   parameter int CNT_W  = 2
) (
   input logic              Clk,
   input logic              Reset,
   grf_scoreboard_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs    [DEPTH];
   logic [CNT_W-1:0]  cnt_arr [DEPTH];
   logic [1:0]        dec_arr [DEPTH];
   logic [ADDR_W-1:0] rd_a    [NUM_RD];
   logic [DEPTH-1:0]  ovf_v;
   logic [DEPTH-1:0]  unf_v;
   logic              sb_err_q;

   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         dec_arr[r] = {1'b0, bus.wr0_clr && (bus.wr0_addr == ADDR_W'(r))} +
                      {1'b0, bus.wr1_clr && (bus.wr1_addr == ADDR_W'(r))};
      end
      dec_arr[REG_ZERO] = 2'd0;
   end

   assign cnt_arr[REG_ZERO] = '0;
   assign ovf_v[REG_ZERO]   = 1'b0;
   assign unf_v[REG_ZERO]   = 1'b0;

   for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
      grf_sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .Clk   (Clk),
         .Reset (Reset),
         .inc   (bus.iss_en && (bus.iss_addr == ADDR_W'(r))),
         .dec   (dec_arr[r]),
         .cnt   (cnt_arr[r]),
         .ovf   (ovf_v[r]),
         .unf   (unf_v[r])
      );
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rda
      assign rd_a[k] = bus.rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];
   end

   // Port 1 wins both the stored value and the bypass path.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (rd_a[k] != ZERO_A) begin
            if ((BYPASS != 0) && !Reset && bus.wr1_en && (bus.wr1_addr == rd_a[k]))
               bus.rd_data[port_lsb(k, DATA_W) +: DATA_W] = bus.wr1_data;
            else if ((BYPASS != 0) && !Reset && bus.wr0_en && (bus.wr0_addr == rd_a[k]))
               bus.rd_data[port_lsb(k, DATA_W) +: DATA_W] = bus.wr0_data;
            else
               bus.rd_data[port_lsb(k, DATA_W) +: DATA_W] = regs[rd_a[k]];
            bus.rd_busy[k] = !Reset &&
               ({2'b00, cnt_arr[rd_a[k]]} > (CNT_W+2)'(dec_arr[rd_a[k]]));
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      end else begin
         if (bus.wr0_en && (bus.wr0_addr != ZERO_A)) regs[bus.wr0_addr] <= bus.wr0_data;
         if (bus.wr1_en && (bus.wr1_addr != ZERO_A)) regs[bus.wr1_addr] <= bus.wr1_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         sb_err_q <= 1'b0;
      else if ((|ovf_v) || (|unf_v))
         sb_err_q <= 1'b1;
   end

   assign bus.sb_err = sb_err_q;
endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Parametrised successor to the pipeline's general register file.
- Provides NUM_RD asynchronous read ports and two synchronous write ports with fixed priority.
- Offers optional same-cycle write-to-read bypass.
- Keeps a per-register pending-write scoreboard, which the hazard unit queries to stall consumers of in-flight results. Sits in the D stage; write ports are fed from W (and a second writeback path, e.g. HI/LO-free MDU result).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
- CNT_W, 2, width of per-register pending counter (max 2**CNT_W-1 outstanding writes)

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  1 = addressed register has an outstanding write after this cycle's clears
- wr0_en  in  1  write port 0 enable
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr0_clr  in  1  write port 0 retires one pending entry of wr0_addr
- wr1_en, wr1_addr, wr1_data, wr1_clr  in  1/ADDR_W/DATA_W/1  write port 1, same meaning
- iss_en  in  1  an instruction writing iss_addr has issued; increment its pending count
- iss_addr  in  ADDR_W  destination of issuing instruction
- sb_err  out  1  sticky: scoreboard overflow or underflow occurred

Behaviour:
- Reset: when Reset is high at a rising edge, all registers and all pending counters become 0 and sb_err becomes 0. Reset overrides all writes, issues and clears in that cycle. While Reset is high, rd_data shows stored values with no bypass, and rd_busy is 0.
- Register 0: reads always return 0; writes to 0 are ignored. Its counter never changes, iss/clr to it is ignored, and its busy bit is always 0.
- Writes: on a rising edge, port wrN_en with nonzero address updates the register.
  - If both ports target the same address, port 1's data is stored.
  - wrN_clr is honoured independently of wrN_en.
- Bypass (BYPASS=1): when rd_addr[k] equals an enabled write address (nonzero), rd_data[k] returns the write data, with port 1 taking priority over port 0. Latency is 0 cycles. With BYPASS=0, the new value is visible the cycle after the edge.
- Pending counter per register; next = cur + inc - dec:
  - inc = iss_en and iss_addr == r.
  - dec = number of clr ports addressing r (0, 1 or 2).
  - Simultaneous iss and clr on the same register yields a net change.
- Overflow: if next would exceed 2**CNT_W-1, the counter saturates at max and sb_err is set.
- Underflow: if next would drop below 0, the counter clamps at 0 and sb_err is set. The data write still occurs.
- rd_busy[k] = (cur - dec for rd_addr[k]) != 0, using combinational clears only. Same-cycle iss does not raise busy until the next cycle.
- sb_err is sticky until Reset.
- All arithmetic is unsigned. The counter path uses CNT_W+1 bits internally to detect over/underflow.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, the REG_ZERO constant, and a function for index slicing of packed port vectors.
- One natural sub-module, grf_sb_counter: a single saturating up/down pending counter with inc, dec[1:0], cnt, ovf and unf outputs. Instantiate it 2**ADDR_W-1 times via generate.

Test Plan:
- Write, then read back: wr0 $5=0x12345678; next cycle, rd_addr0=5 returns 0x12345678 and rd_addr1=0 returns 0.
- Dual write conflict: wr0 and wr1 both to $7, with data 0xAAAA0000 and 0x0000BBBB -> $7 stores 0x0000BBBB. With BYPASS=1, the same-cycle read also returns 0x0000BBBB.
- Write to $0: wr1 $0=0xFFFFFFFF -> rd $0 returns 0; iss to $0 leaves rd_busy 0.
- Scoreboard sequence:
  - iss $9 for two cycles -> rd_busy for $9 is 1.
  - wr0_clr $9 -> rd_busy stays 1.
  - A second clr -> rd_busy drops combinationally in that cycle.
  - Simultaneous iss and clr on $9 leaves the count unchanged.
- Over/underflow: 4 issues to $3 with CNT_W=2 -> count stays 3 and sb_err=1. After Reset, a clr to $4 with count 0 -> sb_err=1 and the data is still written.
- Reset mid-operation: Reset asserted in the same cycle as a wr0 to $2 and an iss to $2 -> $2 reads 0, rd_busy is 0 and sb_err is 0 after the edge.
